// File: rtl/scan_sel_gen_pkg.sv
// Shared types, sizes and channel-search helpers for the channel-scan sequencer.
package scan_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_BLANK = 2'd2
    } state_e;

    // Index of the lowest set bit of m; 0 when m is empty.
    function automatic logic [SEL_W-1:0] first_set(input logic [NCH-1:0] m);
        first_set = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) first_set = SEL_W'(i);
        end
    endfunction

    // Next set bit strictly above cur, wrapping to the lowest set bit.
    function automatic logic [SEL_W-1:0] next_set_wrap(input logic [NCH-1:0] m,
                                                       input logic [SEL_W-1:0] cur);
        logic found;
        next_set_wrap = first_set(m);
        found         = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && m[i] && (i > int'(cur))) begin
                next_set_wrap = SEL_W'(i);
                found         = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/scan_sel_gen_mask_next_ch.sv
// Combinational finder for the channel that follows cur in mask.
module mask_next_ch
    import scan_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] next,
    output logic             wrap
);

    // Next channel plus a flag marking cur as the highest enabled channel.
    always_comb begin
        next = next_set_wrap(mask, cur);
        wrap = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (mask[i] && (i > int'(cur))) wrap = 1'b0;
        end
    end

endmodule

// File: rtl/scan_sel_gen.sv
// Channel-scan sequencer driving a 3-to-8 decoder's select (A) and enable (EN).
module scan_sel_gen
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int BLANK_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [NCH-1:0]     mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [BLANK_W-1:0] blank,
    output logic [SEL_W-1:0]   A,
    output logic               EN,
    output logic               busy,
    output logic               frame_done
);

    localparam int CNT_W = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

    // Remaining-cycle preload for a DRIVE phase; a dwell of 0 behaves as 1.
    function automatic logic [CNT_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : CNT_W'(d) - CNT_W'(1);
    endfunction

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;         // cycles left in current phase after this one
    logic [NCH-1:0]     mask_sh_q, mask_sh_d;
    logic [DWELL_W-1:0] dwell_sh_q, dwell_sh_d;
    logic [BLANK_W-1:0] blank_sh_q, blank_sh_d;
    logic               cont_sh_q, cont_sh_d;
    logic               stop_pending_q, stop_pending_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;

    logic [SEL_W-1:0]   nxt_ch;
    logic               nxt_wrap;
    logic               slot_end;
    logic               last_d;

    mask_next_ch u_next (
        .mask (mask_sh_q),
        .cur  (ch_q),
        .next (nxt_ch),
        .wrap (nxt_wrap)
    );

    // Next-state, shadow and output computation; outputs describe the cycle being entered.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d        = state_q;
        ch_d           = ch_q;
        cnt_d          = cnt_q;
        mask_sh_d      = mask_sh_q;
        dwell_sh_d     = dwell_sh_q;
        blank_sh_d     = blank_sh_q;
        cont_sh_d      = cont_sh_q;
        stop_pending_d = stop_pending_q;
        slot_end       = 1'b0;

        if (state_q != S_IDLE && stop) stop_pending_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start && mask != '0) begin
                    mask_sh_d  = mask;
                    dwell_sh_d = dwell;
                    blank_sh_d = blank;
                    cont_sh_d  = continuous;
                    ch_d       = first_set(mask);
                    cnt_d      = dwell_load(dwell);
                    state_d    = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (blank_sh_q != '0) begin
                    cnt_d   = CNT_W'(blank_sh_q) - CNT_W'(1);
                    state_d = S_BLANK;
                end else begin
                    slot_end = 1'b1;
                end
            end
            S_BLANK: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                else             slot_end = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (slot_end) begin
            if (!nxt_wrap) begin
                ch_d    = nxt_ch;
                cnt_d   = dwell_load(dwell_sh_q);
                state_d = S_DRIVE;
            end else if (cont_sh_q && !stop_pending_q && !stop && mask != '0) begin
                // Frame boundary in continuous mode: pick up fresh settings.
                mask_sh_d  = mask;
                dwell_sh_d = dwell;
                blank_sh_d = blank;
                cont_sh_d  = continuous;
                ch_d       = first_set(mask);
                cnt_d      = dwell_load(dwell);
                state_d    = S_DRIVE;
            end else begin
                cnt_d          = '0;
                stop_pending_d = 1'b0;
                state_d        = S_IDLE;
            end
        end

        en_d   = (state_d == S_DRIVE);
        busy_d = (state_d != S_IDLE);
        last_d = ((state_d == S_DRIVE) && (cnt_d == '0) && (blank_sh_d == '0)) ||
                 ((state_d == S_BLANK) && (cnt_d == '0));
        frame_done_d = last_d && (next_set_wrap(mask_sh_d, ch_d) <= ch_d);
    end

    // State, shadow and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            state_q        <= S_IDLE;
            ch_q           <= '0;
            cnt_q          <= '0;
            mask_sh_q      <= '0;
            dwell_sh_q     <= '0;
            blank_sh_q     <= '0;
            cont_sh_q      <= 1'b0;
            stop_pending_q <= 1'b0;
            en_q           <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            cnt_q          <= cnt_d;
            mask_sh_q      <= mask_sh_d;
            dwell_sh_q     <= dwell_sh_d;
            blank_sh_q     <= blank_sh_d;
            cont_sh_q      <= cont_sh_d;
            stop_pending_q <= stop_pending_d;
            en_q           <= en_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign A          = ch_q;
    assign EN         = en_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Self-checking bench for scan_sel_gen: per-cycle vector table plus frame-length runs.
module tb_scan_sel_gen;

    typedef struct {
        logic       rst, start, stop, cont;
        logic [7:0] mask, dwell;
        logic [3:0] blank;
        logic [2:0] a;
        logic       en, busy, fd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, continuous = 1'b0;
    logic [7:0] mask = '0, dwell = '0;
    logic [3:0] blank = '0;
    logic [2:0] A;
    logic       EN, busy, frame_done;

    int n_vec  = 0;
    int n_fail = 0;

    vec_t tbl[$];
    vec_t sb_q[$];

    scan_sel_gen #(.DWELL_W(8), .BLANK_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .mask       (mask),
        .dwell      (dwell),
        .blank      (blank),
        .A          (A),
        .EN         (EN),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic p, input logic c,
                                input logic [7:0] m, input logic [7:0] d, input logic [3:0] b,
                                input logic [2:0] a, input logic en, input logic bz,
                                input logic fd);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.cont = c;
        v.mask = m; v.dwell = d; v.blank = b;
        v.a = a; v.en = en; v.busy = bz; v.fd = fd;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        rst = v.rst; start = v.start; stop = v.stop; continuous = v.cont;
        mask = v.mask; dwell = v.dwell; blank = v.blank;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_vec++;
        if (A !== e.a || EN !== e.en || busy !== e.busy || frame_done !== e.fd) begin
            n_fail++;
            $display("FAIL %s: got A=%0d EN=%b busy=%b fd=%b, expected A=%0d EN=%b busy=%b fd=%b",
                     tag, A, EN, busy, frame_done, e.a, e.en, e.busy, e.fd);
        end
    endtask

    // One single frame from IDLE; measure busy length, EN-high cycles and frame_done position.
    task automatic run_frame(input logic [7:0] m, input logic [7:0] d, input logic [3:0] b,
                             input int exp_len, input int exp_en);
        int len, en_cnt, fd_cnt, fd_at;
        @(negedge clk);
        rst = 1'b0; start = 1'b1; stop = 1'b0; continuous = 1'b0;
        mask = m; dwell = d; blank = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        len = 0; en_cnt = 0; fd_cnt = 0; fd_at = -1;
        while (busy && len < 400) begin
            len++;
            if (EN) en_cnt++;
            if (frame_done) begin
                fd_cnt++;
                fd_at = len;
            end
            @(posedge clk);
            #1;
        end
        check($sformatf("frame_len m=%0h d=%0d b=%0d", m, d, b), len, exp_len);
        check($sformatf("en_cycles m=%0h d=%0d b=%0d", m, d, b), en_cnt, exp_en);
        check($sformatf("fd_count m=%0h", m), fd_cnt, 1);
        check($sformatf("fd_pos m=%0h", m), fd_at, exp_len);
        check($sformatf("idle_en m=%0h", m), int'(EN), 0);
    endtask

    initial begin
        // Reset
        tbl.push_back(mk(1,0,0,0,8'h00,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,8'h00,0,0, 0,0,0,0));
        // Single frame mask=0000_0101 dwell=2 blank=1; a busy start with other settings is ignored
        tbl.push_back(mk(0,1,0,0,8'h05,2,1, 0,1,1,0));
        tbl.push_back(mk(0,1,0,0,8'hFF,7,3, 0,1,1,0));
        tbl.push_back(mk(0,0,0,0,8'h05,2,1, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,8'h05,2,1, 2,1,1,0));
        tbl.push_back(mk(0,0,0,0,8'h05,2,1, 2,1,1,0));
        tbl.push_back(mk(0,0,0,0,8'h05,2,1, 2,0,1,1));
        tbl.push_back(mk(0,0,0,0,8'h05,2,1, 2,0,0,0));
        // Stop in IDLE must not leave a pending stop behind
        tbl.push_back(mk(0,0,1,0,8'h05,2,1, 2,0,0,0));
        // Start with empty mask is ignored
        tbl.push_back(mk(0,1,0,0,8'h00,2,1, 2,0,0,0));
        tbl.push_back(mk(0,1,0,0,8'h00,2,1, 2,0,0,0));
        // Continuous mask=1000_0001 dwell=0 blank=0, then stop mid-frame
        tbl.push_back(mk(0,1,0,1,8'h81,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h81,0,0, 7,1,1,1));
        tbl.push_back(mk(0,0,0,1,8'h81,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h81,0,0, 7,1,1,1));
        tbl.push_back(mk(0,0,0,1,8'h81,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,1,1,8'h81,0,0, 7,1,1,1));
        tbl.push_back(mk(0,0,0,1,8'h81,0,0, 7,0,0,0));
        // Stop coinciding with the frame-end edge
        tbl.push_back(mk(0,1,0,1,8'h81,0,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h81,0,0, 7,1,1,1));
        tbl.push_back(mk(0,0,1,1,8'h81,0,0, 7,0,0,0));
        tbl.push_back(mk(0,0,0,1,8'h81,0,0, 7,0,0,0));
        // Mid-frame mask/dwell/continuous changes take effect only at frame boundaries
        tbl.push_back(mk(0,1,0,1,8'h03,1,0, 0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h10,2,0, 1,1,1,1));
        tbl.push_back(mk(0,0,0,1,8'h10,2,0, 4,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h10,2,0, 4,1,1,1));
        tbl.push_back(mk(0,0,0,1,8'h10,2,0, 4,1,1,0));
        tbl.push_back(mk(0,0,0,0,8'h10,2,0, 4,1,1,1));
        tbl.push_back(mk(0,0,0,0,8'h10,2,0, 4,1,1,0));
        tbl.push_back(mk(0,0,0,0,8'h10,2,0, 4,1,1,1));
        tbl.push_back(mk(0,0,0,0,8'h10,2,0, 4,0,0,0));
        // Reset while driving channel 3 suppresses the pending frame_done
        tbl.push_back(mk(0,1,0,0,8'h08,2,0, 3,1,1,0));
        tbl.push_back(mk(1,0,0,0,8'h08,2,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,8'h08,2,0, 0,0,0,0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Full-mask sweep: A runs 0..7 on consecutive cycles, EN never drops
        for (int i = 0; i < 8; i++) begin
            apply(mk(0, (i == 0), 0, 0, 8'hFF, 1, 0, 3'(i), 1, 1, (i == 7)),
                  $sformatf("sweep%0d", i));
        end
        apply(mk(0,0,0,0,8'hFF,1,0, 7,0,0,0), "sweep_idle");

        // Frame length = popcount(mask) * (max(dwell,1) + blank)
        run_frame(8'b1011_0010, 3, 2, 20, 12);
        run_frame(8'b1011_0010, 0, 3, 16, 4);
        run_frame(8'b0100_0000, 5, 0, 5, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_sel_gen.md
# scan_sel_gen

Channel-scan sequencer that sits directly upstream of the 3-to-8 decoder and drives its `A` select and `EN` enable. It steps through the channels enabled in an 8-bit mask. Each channel is held for a programmable dwell time, followed by an optional blanking gap with `EN` low to prevent ghosting. The block runs single-frame or continuous, reports frame completion, and its outputs wire straight to the decoder's `A` and `EN`.

## Interface
- `DWELL_W`, default 8: width of the dwell-count input.
- `BLANK_W`, default 4: width of the blank-count input.
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: start a scan; sampled only in IDLE.
- `stop` in 1: request a graceful stop; sampled only while busy.
- `continuous` in 1: 1 repeats frames; 0 runs one frame.
- `mask` in 8: channel enable; bit i enables channel i.
- `dwell` in DWELL_W: `EN`-high cycles per channel; 0 is treated as 1.
- `blank` in BLANK_W: `EN`-low cycles after each channel; 0 means no gap.
- `A` out 3: decoder select (registered).
- `EN` out 1: decoder enable (registered).
- `busy` out 1: high from the first DRIVE cycle until IDLE is re-entered.
- `frame_done` out 1: one-cycle pulse in the final cycle of each frame.

## Operation
- Reset values: `A`=0, `EN`=0, `busy`=0, `frame_done`=0, state IDLE, stop_pending=0, all counters 0.
- States: IDLE, DRIVE, BLANK.

IDLE
- `EN`=0 and `A` holds its last value (0 after reset).
- `start`=1 with `mask`≠0 latches `mask`, `dwell`, `blank` and `continuous` into shadow registers.
- It then loads ch = lowest set bit of mask and enters DRIVE.
- `start` with `mask`=0 is ignored. `stop` is ignored in IDLE.

DRIVE
- `A`=ch, `EN`=1 for max(dwell,1) cycles.
- Then go to BLANK if blank≠0; otherwise the slot ends.

BLANK
- `A` holds ch, `EN`=0 for `blank` cycles; then the slot ends.

Slot end
- next = next set bit above ch, wrapping to the lowest set bit.
- If ch is the highest set bit, this is the frame end:
  - `frame_done`=1 in the last cycle of the slot.
  - If shadow continuous=1 and stop_pending=0, re-sample all four shadow inputs and continue from the lowest set bit of the new mask.
  - If the new mask is 0, go to IDLE instead.
  - Otherwise go to IDLE, clearing stop_pending.
- A single set bit in mask means every slot is a frame end.
- `start` while busy is ignored. Shadow values change only at a frame boundary.
- `stop` while busy sets stop_pending, and the current frame completes normally. `stop` and a frame end in the same cycle: the stop takes effect at that boundary.
- `rst` mid-scan: all outputs take their reset values at the next edge, and no `frame_done` is produced.

## Timing
- Start latency is one edge: `start` sampled at edge n gives `EN`=1, `A`=first ch and `busy`=1 after edge n.
- Frame length = Σ over set bits of (max(dwell,1) + blank).
- The cycle after the last slot of a terminating frame has `EN`=0 and `busy`=0.
- With blank=0, `A` steps channel-to-channel while `EN` stays high, with no glitch cycle.
- Continuous mode has no idle cycle between frames.

## Structure
- Package `scan_pkg` holds:
  - the state enum (`S_IDLE`, `S_DRIVE`, `S_BLANK`);
  - `NCH`=8 and `SEL_W`=3;
  - the `first_set` and `next_set_wrap` functions.
- Sub-module `mask_next_ch`: combinational next-set-bit finder.
  - Inputs: mask[7:0], cur[2:0].
  - Outputs: next[2:0], wrap (1 when no set bit lies above cur).
- The top level contains the FSM, dwell and blank counters, shadow registers and output registers.

## Test plan
- Single frame, mask=0000_0101, dwell=2, blank=1, continuous=0 → `A`=0 with `EN`=1,1,0; then `A`=2 with `EN`=1,1,0 and `frame_done` in the 6th busy cycle; `busy` low from cycle 7.
- Continuous, mask=1000_0001, dwell=0, blank=0 → `EN` stays 1 while `A` alternates 0,7,0,7; `frame_done` each time `A`=7.
  - Then assert `stop` mid-frame → the frame finishes at `A`=7 and the block goes IDLE.
- `mask`=0 with `start` → `busy` stays 0 and `EN` stays 0.
- Mid-frame changes to `mask` and `dwell` in continuous mode → the old values hold until `frame_done`, and the new values apply from the next cycle.
- `rst` pulse during DRIVE on ch 3 → the next cycle shows `A`=0, `EN`=0, `busy`=0 and no `frame_done`.
- mask=1111_1111, dwell=1, blank=0, single frame → `A` runs 0..7 on consecutive cycles with `EN`=1; `frame_done` with `A`=7; 8 busy cycles.
